piso_frame_tx: RTL and testbench
================================

Name: piso_frame_tx

Overview:
Parallel-to-serial frame transmitter that sits directly upstream of the SISO shift-register delay stage and drives its serial input.
- Accepts one DATA_W-bit word per valid/ready handshake.
- Emits a framed bitstream, one bit per clock: start bit, data LSB-first, optional even parity, stop bit(s).
- The line idles low, which matches the low reset state of the downstream delay chain.

Parameters:
DATA_W, 8, payload width in bits (>= 2).
PARITY_EN, 1, 1 = append even-parity bit after data; 0 = no parity bit.
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
clock_in  input  1  single clock; all state updates on its rising edge.
resetn  input  1  asynchronous, active-low reset.
data_in  input  DATA_W  payload word; sampled only on the accept edge.
data_valid  input  1  upstream has a word on data_in.
data_ready  output  1  block can accept a word this cycle.
serial_out  output  1  framed serial bitstream, registered; feeds the SISO serial_in.
busy  output  1  frame in progress (state != IDLE).
frame_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (resetn low, asynchronous):
  - state = IDLE, shift register = 0, bit counter = 0.
  - serial_out = 0, busy = 0, frame_done = 0; data_ready = 1 once reset is released.
  - Reset asserted mid-frame aborts the frame immediately. serial_out drops to 0 and no frame_done pulse is produced.
- Handshake:
  - data_ready = 1 only in IDLE; it is decoded from registered state.
  - A word is accepted on a rising edge where data_valid && data_ready.
  - data_valid asserted while busy is ignored; upstream holds the word until ready.
  - data_in is captured into an internal shift register at accept. Later changes to data_in do not affect the frame in flight.
- State machine: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: serial_out = 0. On accept, load data_in and go to START.
  - START: serial_out = 1 for 1 cycle, then go to DATA.
  - DATA: serial_out = current shift-register LSB; shift right each cycle.
    - Bit counter runs 0..DATA_W-1, with width $clog2(DATA_W).
    - After bit DATA_W-1, go to PARITY if PARITY_EN, else to STOP.
  - PARITY: serial_out = XOR-reduction of the captured word, so data plus parity carries an even count of ones. Lasts 1 cycle, then go to STOP.
  - STOP: serial_out = 0 for STOP_BITS cycles (count reuses the bit counter), then go to IDLE.
- Parity source: the parity bit is computed from a registered copy or a running XOR of the captured word, never from live data_in.
- Latency: accept at edge N -> start bit visible on serial_out after edge N, i.e. during cycle N+1.
- Frame length: 1 + DATA_W + PARITY_EN + STOP_BITS cycles. busy is high for exactly this many cycles.
- frame_done:
  - High for exactly 1 cycle: the first IDLE cycle after the last stop bit.
  - Coincides with data_ready = 1.
- Back-to-back frames:
  - If data_valid is held high, the next word is accepted in the frame_done/IDLE cycle.
  - Minimum gap between frames is exactly 1 idle cycle (serial_out = 0).
- serial_out is driven only from a flop, with no combinational path from inputs, so it can feed the SISO stage directly.

Test Plan:
1. Reset release, then data_valid = 1 with data_in = 0xA5 (DATA_W = 8, PARITY_EN = 1, STOP_BITS = 1):
   - serial_out, starting 1 cycle after accept = 1, 1,0,1,0,0,1,0,1, 0 (parity), 0 (stop).
   - busy high for 11 cycles, then 1-cycle frame_done.
2. data_in = 0x07 with PARITY_EN = 1:
   - Parity bit = 1.
   - data_in changed to 0xFF one cycle after accept; serial output still carries 0x07 (1,1,1,0,0,0,0,0).
3. data_valid held high with words 0x3C then 0xC3:
   - Second start bit occurs exactly 1 idle cycle after the first frame's stop bit.
   - data_ready is low throughout each frame.
4. PARITY_EN = 0, STOP_BITS = 2, data 0x81:
   - Sequence is 1, 1,0,0,0,0,0,0,1, 0,0; frame length 11 cycles.
   - No parity cycle; frame_done pulses once.
5. resetn pulled low during data bit 3 of frame 0xFF:
   - serial_out, busy and frame_done are 0 immediately (asynchronously).
   - No frame_done pulse.
   - After release, data_ready = 1 and a fresh frame 0x55 transmits correctly.
6. Chain with a 4-stage SISO downstream, frame 0xA5:
   - SISO serial_out reproduces scenario 1's sequence delayed by exactly 4 cycles.

Source files
------------

// File: rtl/piso_frame_tx_if.sv
// Word handshake between an upstream word source and piso_frame_tx.
// Latency: none; these are plain wires. Backpressure: the source holds data_in/data_valid until data_ready.
// Ports: data_in (payload), data_valid (source has a word), data_ready (transmitter idle).
interface piso_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;

  // Upstream word source.
  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  // Frame transmitter.
  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/piso_frame_tx.sv
// Parallel-to-serial framer: start(1), data LSB-first, optional even parity, stop(0) bits; line idles low.
// Latency: the start bit appears in the cycle after the accept edge; a frame lasts 1+DATA_W+PARITY_EN+STOP_BITS cycles.
// Backpressure: data_ready is high only in IDLE, so words offered while a frame is in flight wait at the source.
// Ports: clock_in/resetn (async active-low); up (slave handshake: data_in, data_valid, data_ready);
//        serial_out (registered bitstream), busy (frame in progress), frame_done (1-cycle end-of-frame pulse).
module piso_frame_tx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1,
  parameter int STOP_BITS = 1
) (
  input  logic         clock_in,
  input  logic         resetn,
  piso_frame_tx_if.slave up,
  output logic         serial_out,
  output logic         busy,
  output logic         frame_done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              par_q;
  logic              serial_q;
  logic              done_q;
  logic              accept;

  assign accept = up.data_valid && (state_q == S_IDLE);

  // serial_q is always loaded with the value belonging to the state being
  // entered, so the line bit and the state change on the same edge.
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          serial_q <= 1'b0;
          if (accept) begin
            shreg_q  <= up.data_in;
            par_q    <= 1'b0;
            cnt_q    <= '0;
            serial_q <= 1'b1;
            state_q  <= S_START;
          end
        end
        S_START: begin
          // First data bit goes out; parity accumulates each bit as it is sent.
          serial_q <= shreg_q[0];
          par_q    <= par_q ^ shreg_q[0];
          shreg_q  <= shreg_q >> 1;
          cnt_q    <= '0;
          state_q  <= S_DATA;
        end
        S_DATA: begin
          if (cnt_q == LAST_DATA) begin
            // par_q now holds the XOR of the whole captured word.
            cnt_q <= '0;
            if (PARITY_EN != 0) begin
              serial_q <= par_q;
              state_q  <= S_PARITY;
            end else begin
              serial_q <= 1'b0;
              state_q  <= S_STOP;
            end
          end else begin
            serial_q <= shreg_q[0];
            par_q    <= par_q ^ shreg_q[0];
            shreg_q  <= shreg_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          serial_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= S_STOP;
        end
        S_STOP: begin
          serial_q <= 1'b0;
          if (cnt_q == LAST_STOP) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          serial_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign serial_out    = serial_q;
  assign frame_done    = done_q;
  assign busy          = (state_q != S_IDLE);
  assign up.data_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_piso_frame_tx.sv
// Bench for piso_frame_tx: two instances (parity+1 stop, no parity+2 stops) plus a 4-stage delay chain.
// Expected frames are built from the word as a bit list; each line cycle is compared at the falling edge.
module tb_piso_frame_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  piso_frame_tx_if #(.DATA_W(8)) if0 ();
  piso_frame_tx_if #(.DATA_W(8)) if1 ();

  logic so0, bz0, fd0, so1, bz1, fd1;

  piso_frame_tx #(.DATA_W(8), .PARITY_EN(1), .STOP_BITS(1)) dut0 (
    .clock_in  (clk),
    .resetn    (rst_n),
    .up        (if0),
    .serial_out(so0),
    .busy      (bz0),
    .frame_done(fd0)
  );

  piso_frame_tx #(.DATA_W(8), .PARITY_EN(0), .STOP_BITS(2)) dut1 (
    .clock_in  (clk),
    .resetn    (rst_n),
    .up        (if1),
    .serial_out(so1),
    .busy      (bz1),
    .frame_done(fd1)
  );

  // Downstream 4-stage SISO delay chain fed by dut0.
  logic [3:0] siso_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) siso_q <= 4'b0;
    else        siso_q <= {siso_q[2:0], so0};
  end

  int total = 0;
  int bad   = 0;
  bit exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame as the line should carry it: 1, data LSB first, even parity, stop zeros.
  task automatic build(input logic [7:0] w, input bit pen, input int stops);
    exp_q = {};
    exp_q.push_back(1'b1);
    for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
    if (pen) exp_q.push_back(($countones(w) % 2) == 1);
    for (int i = 0; i < stops; i++) exp_q.push_back(1'b0);
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin
      if0.data_valid = v;
      if0.data_in    = d;
    end else begin
      if1.data_valid = v;
      if1.data_in    = d;
    end
  endtask

  // {ready, serial, busy, done}
  function automatic logic [3:0] obs(input int sel);
    if (sel == 0) return {if0.data_ready, so0, bz0, fd0};
    else          return {if1.data_ready, so1, bz1, fd1};
  endfunction

  // One full frame on instance sel. preloaded: the word was already offered in
  // the previous frame_done cycle. chain: offer nw in this frame's done cycle.
  task automatic tx(input int sel, input logic [7:0] w, input bit mutate,
                    input bit preloaded, input bit chain, input logic [7:0] nw);
    logic [3:0] o;
    build(w, sel == 0, (sel == 0) ? 1 : 2);
    if (!preloaded) begin
      o = obs(sel);
      chk($sformatf("ready_idle_u%0d", sel), o[3], 1);
      drive(sel, 1'b1, w);
    end
    @(negedge clk);
    drive(sel, 1'b0, mutate ? 8'hFF : w);
    for (int i = 0; i < exp_q.size(); i++) begin
      o = obs(sel);
      chk($sformatf("bit%0d_u%0d_w%02h", i, sel, w), o[2], exp_q[i]);
      chk($sformatf("busy%0d_u%0d", i, sel), o[1], 1);
      chk($sformatf("ready_busy%0d_u%0d", i, sel), o[3], 0);
      chk($sformatf("done_early%0d_u%0d", i, sel), o[0], 0);
      @(negedge clk);
    end
    o = obs(sel);
    chk($sformatf("done_u%0d", sel), o[0], 1);
    chk($sformatf("ready_done_u%0d", sel), o[3], 1);
    chk($sformatf("busy_done_u%0d", sel), o[1], 0);
    chk($sformatf("gap_u%0d", sel), o[2], 0);
    if (chain) begin
      drive(sel, 1'b1, nw);
    end else begin
      @(negedge clk);
      o = obs(sel);
      chk($sformatf("done_once_u%0d", sel), o[0], 0);
    end
  endtask

  initial begin
    logic [7:0] w, nw;
    bit pre, ch, e, es;
    int s;

    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_serial0", so0, 0);
    chk("rst_busy0", bz0, 0);
    chk("rst_done0", fd0, 0);
    chk("rst_serial1", so1, 0);
    chk("rst_busy1", bz1, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready0", if0.data_ready, 1);
    chk("rel_ready1", if1.data_ready, 1);

    // Directed frames.
    tx(0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
    tx(0, 8'h07, 1'b1, 1'b0, 1'b0, 8'h00);
    tx(0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hC3);
    tx(0, 8'hC3, 1'b0, 1'b1, 1'b0, 8'h00);
    tx(1, 8'h81, 1'b0, 1'b0, 1'b0, 8'h00);

    // Reset during data bit 3 of 0xFF.
    drive(0, 1'b1, 8'hFF);
    @(negedge clk);
    drive(0, 1'b0, 8'hFF);
    repeat (4) @(negedge clk);
    chk("abort_pre_bit3", so0, 1);
    chk("abort_pre_busy", bz0, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_serial", so0, 0);
    chk("abort_busy", bz0, 0);
    chk("abort_done", fd0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("abort_nodone%0d", i), fd0, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_nodone_rel", fd0, 0);
    chk("abort_ready", if0.data_ready, 1);
    tx(0, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00);

    // 0xA5 through the 4-stage delay chain.
    repeat (5) @(negedge clk);
    build(8'hA5, 1'b1, 1);
    drive(0, 1'b1, 8'hA5);
    @(negedge clk);
    drive(0, 1'b0, 8'hA5);
    for (int k = 0; k < 16; k++) begin
      e  = (k < exp_q.size()) ? exp_q[k] : 1'b0;
      es = (k >= 4 && (k - 4) < exp_q.size()) ? exp_q[k-4] : 1'b0;
      chk($sformatf("chain_src%0d", k), so0, e);
      chk($sformatf("chain_siso%0d", k), siso_q[3], es);
      @(negedge clk);
    end

    // Random words, instances, data_in churn, back-to-back chaining and gaps.
    pre = 1'b0;
    s   = 0;
    w   = 8'($urandom);
    for (int n = 0; n < 40; n++) begin
      ch = (n < 39) && ($urandom_range(0, 1) == 1);
      nw = 8'($urandom);
      if (!pre) s = $urandom_range(0, 1);
      tx(s, w, $urandom_range(0, 1) == 1, pre, ch, nw);
      pre = ch;
      w   = nw;
      if (!ch) repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
